clkdiv_monitor: RTL

Monitors a divided clock (e.g. the `clk4` output of `clkdiv4`) in the fast `clk` domain. It measures the period and high time of every divided-clock cycle, checks them against the expected ratio, and reports lock and error status. It is the consumer-side checker that sits next to every clock divider in the design.

---
 rtl/clkdiv_pkg.sv | 26 ++
 rtl/clkdiv_edge_det.sv | 31 +++
 rtl/clkdiv_monitor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, defaults and helpers for divided-clock checkers
//
// Contents:
//   DEF_DIV, DEF_CNT_W, DEF_LOCK_CYCLES  default parameter values
//   state_t                              monitor FSM state encoding
//   stall_limit()                        cycles without a rise that count as a stall
package clkdiv_pkg;

  localparam int DEF_DIV         = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // A healthy divided clock rises every DIV cycles; twice that with no rise
  // means the divider has stopped.
  function automatic int stall_limit(input int div);
    return 2 * div;
  endfunction

endpackage

// File: rtl/clkdiv_edge_det.sv
// rtl/clkdiv_edge_det.sv - single-register rise/fall detector for a clk-domain signal
//
// Ports:
//   clk   in   reference clock, posedge
//   rst_  in   asynchronous active-low reset
//   sig   in   signal to watch, already in the clk domain
//   rise  out  sig is 1 now and was 0 on the previous edge (combinational)
//   fall  out  sig is 0 now and was 1 on the previous edge (combinational)
module clkdiv_edge_det (
  input  logic clk,
  input  logic rst_,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev <= 1'b0;
    end else begin
      prev <= sig;
    end
  end

  // Combinational so the consumer acts on the same edge that samples the change.
  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/clkdiv_monitor.sv
// rtl/clkdiv_monitor.sv - period/high-time checker with lock and error reporting for a divided clock
//
// Parameters:
//   DIV          expected division ratio (even, >= 2)
//   CNT_W        measurement counter width (2^CNT_W-1 >= 2*DIV)
//   LOCK_CYCLES  consecutive good periods needed to lock
//
// Ports:
//   clk         in   fast reference clock, posedge
//   rst_        in   asynchronous active-low reset
//   clk_in      in   divided clock under test, generated in the clk domain
//   en          in   monitor enable; 0 holds the monitor idle
//   err_clr     in   clears err_sticky (a same-cycle error wins)
//   locked      out  high while locked
//   err_pulse   out  one-cycle pulse per detected error
//   err_sticky  out  latched error flag
//   period      out  last measured period in clk cycles
//   high_time   out  last measured high time in clk cycles
module clkdiv_monitor
  import clkdiv_pkg::*;
#(
  parameter int DIV         = DEF_DIV,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clk_in,
  input  logic             en,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  DIV_V     = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]  HALF_V    = CNT_W'(DIV / 2);
  // cnt is compared one below the limit so the error lands on the edge
  // where cnt becomes 2*DIV.
  localparam logic [CNT_W-1:0]  STALL_PRE = CNT_W'(stall_limit(DIV) - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CYCLES);

  logic              rise;
  logic              fall;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  meas;
  logic              good_period;
  logic              stall;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_inc;
  logic [GOOD_W-1:0] good_next;
  logic              err;
  state_t            state;
  state_t            state_next;

  clkdiv_edge_det u_edge (
    .clk  (clk),
    .rst_ (rst_),
    .sig  (clk_in),
    .rise (rise),
    .fall (fall)
  );

  // ---------------------------------------------------------------------------
  // Measurement
  // ---------------------------------------------------------------------------

  // Period ending at this rise; pinned at CNT_MAX once cnt has saturated so a
  // stuck input can never alias onto a valid period.
  assign meas        = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  // high_time still holds the high phase of the period that is ending here.
  assign good_period = (meas == DIV_V) && (high_time == HALF_V);
  // A rise on the limit edge is judged as a (bad) period instead.
  assign stall       = ~rise && (cnt == STALL_PRE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        cnt    <= '0;
        hcnt   <= CNT_ONE;
        period <= meas;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
        end
        if (clk_in && (hcnt != CNT_MAX)) begin
          hcnt <= hcnt + CNT_ONE;
        end
      end
      if (fall) begin
        high_time <= hcnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------

  assign good_inc = good + GOOD_ONE;

  always_comb begin
    state_next = state;
    good_next  = good;
    err        = 1'b0;

    if (!en) begin
      state_next = ST_IDLE;
      good_next  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_next = ST_SEARCH;
          good_next  = '0;
        end

        // The first rise only aligns the counters; the period before it is
        // unknown and must not be judged.
        ST_SEARCH: begin
          if (rise) begin
            state_next = ST_MEASURE;
            good_next  = '0;
          end
        end

        ST_MEASURE: begin
          if (rise) begin
            if (good_period) begin
              if (good_inc == GOOD_LOCK) begin
                state_next = ST_LOCKED;
                good_next  = '0;
              end else begin
                good_next = good_inc;
              end
            end else begin
              err       = 1'b1;
              good_next = '0;
            end
          end else if (stall) begin
            err        = 1'b1;
            good_next  = '0;
            state_next = ST_SEARCH;
          end
        end

        ST_LOCKED: begin
          if (rise) begin
            if (!good_period) begin
              err        = 1'b1;
              good_next  = '0;
              state_next = ST_MEASURE;
            end
          end else if (stall) begin
            err        = 1'b1;
            good_next  = '0;
            state_next = ST_SEARCH;
          end
        end

        default: begin
          state_next = ST_IDLE;
          good_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= ST_IDLE;
      good       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_next;
      good       <= good_next;
      locked     <= (state_next == ST_LOCKED);
      err_pulse  <= err;
      // A new error outranks a simultaneous clear.
      err_sticky <= err | (err_sticky & ~err_clr);
    end
  end

endmodule
